// File: rtl/ppu_hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard/forwarding controller.
package ppu_hazard_pkg;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] FWD_RF  = 2'd0;
    localparam logic [SEL_W-1:0] FWD_EX  = 2'd1;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'd2;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    // True when a counter of width w (w <= 32) holds its all-ones value.
    function automatic logic cnt_saturated(input logic [31:0] v, input int unsigned w);
        logic [31:0] vmax;
        vmax = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return v == vmax;
    endfunction

endpackage

// File: rtl/hazard_forwarding_unit_forward_select.sv
// Per-operand priority matcher: picks the nearest producing stage (EX > MEM > WB)
// and flags an EX-stage load match, which cannot be forwarded.
module forward_select
    import ppu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 3,
    parameter int LOAD_STALL = 1
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_uses,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_ex_en,
    input  logic                  i_mem_en,
    input  logic                  i_wb_en,
    input  logic                  i_ex_load,
    input  logic                  i_mem_load,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_load_hit
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_ex_hit  = (NUM_FWD >= 1) && i_uses && i_ex_en
                       && (i_ex_rd != '0) && (i_ex_rd == i_rs);
    // A multi-cycle load still sitting in MEM has no data yet.
    assign w_mem_hit = (NUM_FWD >= 2) && i_uses && i_mem_en
                       && (i_mem_rd != '0) && (i_mem_rd == i_rs)
                       && !((LOAD_STALL > 1) && i_mem_load);
    assign w_wb_hit  = (NUM_FWD >= 3) && i_uses && i_wb_en
                       && (i_wb_rd != '0) && (i_wb_rd == i_rs);

    // An EX load match shadows older stages: their values are stale.
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit)       o_sel = i_ex_load ? FWD_RF : FWD_EX;
        else if (w_mem_hit) o_sel = FWD_MEM;
        else if (w_wb_hit)  o_sel = FWD_WB;
    end

    assign o_load_hit = w_ex_hit && i_ex_load;

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and forwarding control: operand-mux selects, load-use stall
// sequencing, taken-branch flushes and saturating stall/flush counters.
module hazard_forwarding_unit
    import ppu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 3,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] RS1,
    input  logic [REG_ADDR_W-1:0] RS2,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic [REG_ADDR_W-1:0] MEM_RD,
    input  logic [REG_ADDR_W-1:0] WB_RD,
    input  logic                  EX_RF_enable,
    input  logic                  MEM_RF_enable,
    input  logic                  WB_RF_enable,
    input  logic                  EX_load_Instr,
    input  logic                  MEM_load_Instr,
    input  logic                  branch_taken,
    output logic [SEL_W-1:0]      MUX_PA_E,
    output logic [SEL_W-1:0]      MUX_PB_E,
    output logic                  PC_E,
    output logic                  IF_ID_E,
    output logic                  CUMUX_E,
    output logic                  reset_IF_ID,
    output logic                  reset_ID_EX,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [1:0] REM_INIT = 2'((LOAD_STALL >= 2) ? (LOAD_STALL - 2) : 0);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [1:0]       r_rem;
    logic [1:0]       w_rem_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [SEL_W-1:0] w_sel_pa;
    logic [SEL_W-1:0] w_sel_pb;
    logic             w_pa_hit;
    logic             w_pb_hit;
    logic             w_hazard;
    logic             w_bubble;

    forward_select #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .LOAD_STALL(LOAD_STALL)
    ) u_fwd_pa (
        .i_rs(RS1), .i_uses(uses_rs1),
        .i_ex_rd(EX_RD), .i_mem_rd(MEM_RD), .i_wb_rd(WB_RD),
        .i_ex_en(EX_RF_enable), .i_mem_en(MEM_RF_enable), .i_wb_en(WB_RF_enable),
        .i_ex_load(EX_load_Instr), .i_mem_load(MEM_load_Instr),
        .o_sel(w_sel_pa), .o_load_hit(w_pa_hit)
    );

    forward_select #(
        .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .LOAD_STALL(LOAD_STALL)
    ) u_fwd_pb (
        .i_rs(RS2), .i_uses(uses_rs2),
        .i_ex_rd(EX_RD), .i_mem_rd(MEM_RD), .i_wb_rd(WB_RD),
        .i_ex_en(EX_RF_enable), .i_mem_en(MEM_RF_enable), .i_wb_en(WB_RF_enable),
        .i_ex_load(EX_load_Instr), .i_mem_load(MEM_load_Instr),
        .o_sel(w_sel_pb), .o_load_hit(w_pb_hit)
    );

    assign w_hazard = w_pa_hit | w_pb_hit;

    // A taken branch kills whatever would have been stalled, so it wins outright.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_bubble    = 1'b0;
        if (branch_taken) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hazard) begin
                        w_bubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            w_state_nxt = STALL;
                            w_rem_nxt   = REM_INIT;
                        end
                    end
                end
                STALL: begin
                    w_bubble = 1'b1;
                    if (r_rem == 2'd0) w_state_nxt = IDLE;
                    else               w_rem_nxt   = r_rem - 2'd1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign PC_E        = Reset | ~w_bubble;
    assign IF_ID_E     = Reset | ~w_bubble;
    assign CUMUX_E     = ~Reset & w_bubble;
    assign reset_IF_ID = ~Reset & branch_taken;
    assign reset_ID_EX = ~Reset & branch_taken;
    assign MUX_PA_E    = Reset ? FWD_RF : w_sel_pa;
    assign MUX_PB_E    = Reset ? FWD_RF : w_sel_pb;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_bubble && !cnt_saturated(32'(r_stall_cnt), CNT_W))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (branch_taken && !cnt_saturated(32'(r_flush_cnt), CNT_W))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule
